// File: rtl/iot_riscv_irq_ctrl_pkg.sv
// iot_riscv_irq_ctrl_pkg: register map indices and helpers for the interrupt source controller
package iot_riscv_irq_ctrl_pkg;
    localparam logic [2:0] reg_pending_c = 3'd0;
    localparam logic [2:0] reg_enable_c  = 3'd1;
    localparam logic [2:0] reg_edge_c    = 3'd2;
    localparam logic [2:0] reg_set_c     = 3'd3;
    localparam logic [2:0] reg_id_c      = 3'd4;
    localparam int id_valid_bit_c = 31;

    function automatic logic [4:0] lowest_set_idx(input logic [31:0] v);
        lowest_set_idx = '0;
        for (int i = 31; i >= 0; i--) if (v[i]) lowest_set_idx = 5'(i);
    endfunction
endpackage

// File: rtl/iot_riscv_irq_ctrl_sync.sv
// iot_riscv_irq_ctrl_sync: N-stage synchroniser with async reset to 0; zero stages is a plain wire
module iot_riscv_irq_ctrl_sync #(
    parameter int width_p  = 1,
    parameter int stages_p = 2
) (
    input  logic               clk_i,
    input  logic               rst_an_i,
    input  logic [width_p-1:0] d,
    output logic [width_p-1:0] q
);
    if (stages_p == 0) begin : g_bypass
        assign q = d;
    end else begin : g_sync
        logic [width_p-1:0] ff_r [stages_p];
        always_ff @(posedge clk_i or negedge rst_an_i)
            if (!rst_an_i) ff_r <= '{default: '0};
            else begin
                ff_r[0] <= d;
                for (int i = 1; i < stages_p; i++) ff_r[i] <= ff_r[i-1];
            end
        assign q = ff_r[stages_p-1];
    end
endmodule

// File: rtl/iot_riscv_irq_ctrl.sv
// iot_riscv_irq_ctrl: peripheral interrupt source controller with level/edge detect and register bus
module iot_riscv_irq_ctrl import iot_riscv_irq_ctrl_pkg::*; #(
    parameter int irq_width_p   = 32,
    parameter int sync_stages_p = 2
) (
    input  logic                   main_clk_i,
    input  logic                   main_rst_an_i,
    input  logic [irq_width_p-1:0] src_irq_i,
    input  logic                   bus_req_i,
    input  logic                   bus_wr_i,
    input  logic [2:0]             bus_addr_i,
    input  logic [31:0]            bus_wdata_i,
    output logic [31:0]            bus_rdata_o,
    output logic                   bus_ack_o,
    output logic [irq_width_p-1:0] irq_o,
    output logic [irq_width_p-1:0] irq_mask_o
);
    logic [irq_width_p-1:0] sync_s, prev_r, rise_s, en_r, edge_r, edge_pend_r, pend_s, wd, set_s, clr_s;
    logic [31:0] act_s, id_s, rd_s;
    logic wr_s, wr_pend, wr_en, wr_edge, wr_set;

    iot_riscv_irq_ctrl_sync #(.width_p(irq_width_p), .stages_p(sync_stages_p)) u_sync (
        .clk_i(main_clk_i),
        .rst_an_i(main_rst_an_i),
        .d(src_irq_i),
        .q(sync_s)
    );

    assign rise_s  = sync_s & ~prev_r;
    assign pend_s  = (edge_pend_r & edge_r) | (sync_s & ~edge_r);
    assign wd      = bus_wdata_i[irq_width_p-1:0];
    assign wr_s    = bus_req_i & bus_wr_i;
    assign wr_pend = wr_s & (bus_addr_i == reg_pending_c);
    assign wr_en   = wr_s & (bus_addr_i == reg_enable_c);
    assign wr_edge = wr_s & (bus_addr_i == reg_edge_c);
    assign wr_set  = wr_s & (bus_addr_i == reg_set_c);
    // set wins over clear; clearing also happens when a bit leaves edge mode
    assign set_s   = (rise_s | ({irq_width_p{wr_set}} & wd)) & edge_r;
    assign clr_s   = ({irq_width_p{wr_pend}} & wd) | ({irq_width_p{wr_edge}} & edge_r & ~wd);
    assign act_s   = 32'(pend_s & en_r);

    always_comb begin
        id_s = '0;
        id_s[id_valid_bit_c] = |act_s;
        id_s[4:0] = lowest_set_idx(act_s);
    end

    always_comb begin
        rd_s = '0;
        case (bus_addr_i)
            reg_pending_c: rd_s = 32'(pend_s);
            reg_enable_c:  rd_s = 32'(en_r);
            reg_edge_c:    rd_s = 32'(edge_r);
            reg_id_c:      rd_s = id_s;
            default:       rd_s = '0;
        endcase
    end

    always_ff @(posedge main_clk_i or negedge main_rst_an_i)
        if (!main_rst_an_i) begin
            prev_r      <= '0;
            en_r        <= '0;
            edge_r      <= '0;
            edge_pend_r <= '0;
            bus_ack_o   <= 1'b0;
            bus_rdata_o <= '0;
        end else begin
            prev_r      <= sync_s;
            en_r        <= wr_en ? wd : en_r;
            edge_r      <= wr_edge ? wd : edge_r;
            edge_pend_r <= set_s | (edge_pend_r & ~clr_s);
            bus_ack_o   <= bus_req_i;
            bus_rdata_o <= (bus_req_i && !bus_wr_i) ? rd_s : '0;
        end

    assign irq_o      = pend_s;
    assign irq_mask_o = en_r;
endmodule

// File: tb/tb_iot_riscv_irq_ctrl.sv
// tb_iot_riscv_irq_ctrl: scoreboard bench for the interrupt source controller
module tb_iot_riscv_irq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] src = '0;
    logic        bus_req = 1'b0, bus_wr = 1'b0;
    logic [2:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata_o, irq_o, irq_mask_o;
    logic        bus_ack_o;
    logic [32:0] sb [$];
    logic [32:0] e;
    int total = 0, bad = 0;

    iot_riscv_irq_ctrl dut (
        .main_clk_i(clk),
        .main_rst_an_i(rst_n),
        .src_irq_i(src),
        .bus_req_i(bus_req),
        .bus_wr_i(bus_wr),
        .bus_addr_i(bus_addr),
        .bus_wdata_i(bus_wdata),
        .bus_rdata_o(bus_rdata_o),
        .bus_ack_o(bus_ack_o),
        .irq_o(irq_o),
        .irq_mask_o(irq_mask_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input logic c);
        bus_req = 1'b1; bus_wr = w; bus_addr = a; bus_wdata = d;
        sb.push_back({c, exp});
        tick();
    endtask

    task automatic idle();
        bus_req = 1'b0; bus_wr = 1'b0;
    endtask

    task automatic pulse(input int b);
        src[b] = 1'b1;
        tick();
        src[b] = 1'b0;
        tick();
    endtask

    always @(negedge clk)
        if (rst_n && bus_ack_o) begin
            if (sb.size() == 0) chk("ack_unexpected", {31'b0, bus_ack_o}, 32'h0);
            else begin
                e = sb.pop_front();
                if (e[32]) chk("rdata", bus_rdata_o, e[31:0]);
            end
        end

    initial begin
        #12 rst_n = 1'b1;
        chk("rst_irq", irq_o, 32'h0);
        chk("rst_mask", irq_mask_o, 32'h0);
        chk("rst_ack", {31'b0, bus_ack_o}, 32'h0);
        chk("rst_rdata", bus_rdata_o, 32'h0);
        tick();
        // level
        bus(1, 3'd1, 32'h1, 0, 0); idle();
        chk("lvl_mask", irq_mask_o, 32'h1);
        src[0] = 1'b1;
        tick(); chk("lvl_k", irq_o, 32'h0);
        tick(); chk("lvl_k1", irq_o, 32'h1);
        bus(1, 3'd0, 32'h1, 0, 0); idle();
        chk("lvl_w1c", irq_o, 32'h1);
        src[0] = 1'b0;
        tick(); chk("lvl_fall_k", irq_o, 32'h1);
        tick(); chk("lvl_fall_k1", irq_o, 32'h0);
        // edge
        bus(1, 3'd2, 32'h4, 0, 0); idle();
        bus(0, 3'd2, 0, 32'h4, 1); idle();
        pulse(2); chk("edge_k1", irq_o, 32'h0);
        tick(); chk("edge_k2", irq_o, 32'h4);
        tick(); tick(); chk("edge_hold", irq_o, 32'h4);
        bus(0, 3'd0, 0, 32'h4, 1); idle();
        bus(1, 3'd0, 32'h4, 0, 0); idle();
        chk("edge_w1c", irq_o, 32'h0);
        // collision: W1C coincides with a new rise
        pulse(2); tick(); chk("coll_pre", irq_o, 32'h4);
        pulse(2);
        bus(1, 3'd0, 32'h4, 0, 0); idle();
        chk("coll_set_wins", irq_o, 32'h4);
        tick(); bus(1, 3'd0, 32'h4, 0, 0); idle();
        chk("coll_clear", irq_o, 32'h0);
        bus(1, 3'd3, 32'h5, 0, 0); idle();
        chk("set_edge_only", irq_o, 32'h4);
        bus(0, 3'd3, 0, 32'h0, 1); idle();
        // id
        bus(1, 3'd2, 32'h28, 0, 0); idle();
        chk("edge_off_clears", irq_o, 32'h0);
        bus(1, 3'd3, 32'h28, 0, 0); idle();
        chk("pend_28", irq_o, 32'h28);
        bus(1, 3'd1, 32'h20, 0, 0);
        bus(0, 3'd4, 0, 32'h8000_0005, 1);
        bus(0, 3'd4, 0, 32'h8000_0005, 1);
        bus(1, 3'd1, 32'h28, 0, 0);
        bus(0, 3'd4, 0, 32'h8000_0003, 1);
        bus(1, 3'd1, 32'h0, 0, 0);
        bus(0, 3'd4, 0, 32'h0, 1);
        bus(0, 3'd0, 0, 32'h28, 1); idle();
        // bus
        bus(1, 3'd1, 32'hFF, 0, 0);
        chk("b2b_ack0", {31'b0, bus_ack_o}, 32'h1);
        bus(0, 3'd1, 0, 32'hFF, 1);
        chk("b2b_ack1", {31'b0, bus_ack_o}, 32'h1);
        bus(1, 3'd7, 32'hFFFF_FFFF, 0, 0);
        bus(0, 3'd6, 0, 32'h0, 1);
        bus(0, 3'd1, 0, 32'hFF, 1); idle();
        tick();
        chk("idle_ack", {31'b0, bus_ack_o}, 32'h0);
        chk("idle_rdata", bus_rdata_o, 32'h0);
        for (int i = 0; i < 4 && sb.size() != 0; i++) tick();
        chk("sb_drained", sb.size(), 32'h0);
        // reset mid-read with edge bits pending
        chk("pre_rst_irq", irq_o, 32'h28);
        bus_req = 1'b1; bus_wr = 1'b0; bus_addr = 3'd0;
        tick();
        chk("pre_rst_ack", {31'b0, bus_ack_o}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_irq", irq_o, 32'h0);
        chk("rst_mid_mask", irq_mask_o, 32'h0);
        chk("rst_mid_ack", {31'b0, bus_ack_o}, 32'h0);
        idle();
        src[2] = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_level", irq_o, 32'h4);
        bus(1, 3'd2, 32'h4, 0, 0); idle();
        tick(); tick(); tick();
        chk("post_rst_no_pend", irq_o, 32'h0);
        for (int i = 0; i < 4 && sb.size() != 0; i++) tick();
        chk("sb_final", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
